// File: rtl/memory_arbiter_2p.sv
// Two-port arbiter in front of a single registered-read memory: grant is combinational, the access issues at the grant-cycle edge, and read data returns one cycle later.
// No queueing: a losing requester holds its request; round-robin guarantees a grant within 2 cycles.
module memory_arbiter_2p #(
    parameter int WIDTH      = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic                 a_wr,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [WIDTH-1:0]     a_rdata,
    input  logic                 b_req,
    input  logic                 b_wr,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [WIDTH-1:0]     b_rdata,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_wa,
    output logic [ADDR_SIZE-1:0] mem_ra,
    output logic [WIDTH-1:0]     mem_din,
    input  logic [WIDTH-1:0]     mem_dout
);

    localparam logic W_FIXED = (FIXED_PRIO != 0);

    logic                 w_a_gnt;
    logic                 w_b_gnt;
    logic                 w_a_rvalid;
    logic                 w_b_rvalid;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [WIDTH-1:0]     w_din;

    logic                 r_last_b;
    logic                 r_rd_pend;
    logic                 r_rd_port;
    logic [WIDTH-1:0]     r_a_rdata;
    logic [WIDTH-1:0]     r_b_rdata;

    // A wins a tie under fixed priority, or when B was the last port served.
    assign w_a_gnt = reset_n & a_req & (~b_req | W_FIXED | r_last_b);
    assign w_b_gnt = reset_n & b_req & ~w_a_gnt;

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        if (w_a_gnt) begin
            w_addr = a_addr;
            w_din  = a_wdata;
        end else if (w_b_gnt) begin
            w_addr = b_addr;
            w_din  = b_wdata;
        end
    end

    assign a_gnt   = w_a_gnt;
    assign b_gnt   = w_b_gnt;
    assign mem_wen = (w_a_gnt & a_wr) | (w_b_gnt & b_wr);
    assign mem_wa  = w_addr;
    assign mem_ra  = w_addr;
    assign mem_din = w_din;

    assign w_a_rvalid = r_rd_pend & ~r_rd_port;
    assign w_b_rvalid = r_rd_pend &  r_rd_port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b  <= 1'b1;
            r_rd_pend <= 1'b0;
            r_rd_port <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_a_gnt)
                r_last_b <= 1'b0;
            else if (w_b_gnt)
                r_last_b <= 1'b1;
            r_rd_pend <= (w_a_gnt & ~a_wr) | (w_b_gnt & ~b_wr);
            r_rd_port <= w_b_gnt;
            // Capture the returned word so rdata holds once rvalid drops.
            if (w_a_rvalid)
                r_a_rdata <= mem_dout;
            if (w_b_rvalid)
                r_b_rdata <= mem_dout;
        end
    end

    assign a_rvalid = w_a_rvalid;
    assign b_rvalid = w_b_rvalid;
    assign a_rdata  = w_a_rvalid ? mem_dout : r_a_rdata;
    assign b_rdata  = w_b_rvalid ? mem_dout : r_b_rdata;

endmodule
